// File: rtl/main_control_sequencer_pkg.sv
`default_nettype none
// edsac_ctl_pkg: timing constants and stage encoding shared by the main control,
// order decoder and arithmetic control.
package edsac_ctl_pkg;

   localparam int DIGITS  = 36;
   localparam int MINORS  = 16;
   localparam int DIGIT_W = 6;
   localparam int MINOR_W = 4;
   localparam int EXEC_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S1   = 2'd1,
      S2   = 2'd2
   } state_t;

   // A zero-length Stage 2 still needs one major cycle to execute.
   function automatic logic [EXEC_W-1:0] clamp_len(input logic [EXEC_W-1:0] len);
      return (len == '0) ? {{(EXEC_W-1){1'b0}}, 1'b1} : len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/main_control_sequencer_if.sv
`default_nettype none
// main_control_sequencer_if: panel/decoder inputs and timing/stage outputs of the
// main control sequencer.
interface main_control_sequencer_if;

   logic                                start;
   logic                                stop_req;
   logic                                single_shot;
   logic                                stop_order;
   logic [edsac_ctl_pkg::EXEC_W-1:0]    exec_len;
   logic                                order_flash_rdy;
   logic [edsac_ctl_pkg::DIGITS-1:0]    d;
   logic [edsac_ctl_pkg::MINOR_W-1:0]   minor;
   logic                                g12;
   logic                                g13;
   logic                                eps1;
   logic                                epsep;
   logic                                running;
   logic                                flash_fault;

   modport master (
      output start, stop_req, single_shot, stop_order, exec_len, order_flash_rdy,
      input  d, minor, g12, g13, eps1, epsep, running, flash_fault
   );

   modport slave (
      input  start, stop_req, single_shot, stop_order, exec_len, order_flash_rdy,
      output d, minor, g12, g13, eps1, epsep, running, flash_fault
   );

endinterface
`default_nettype wire

// File: rtl/main_control_sequencer_digit_timer.sv
`default_nettype none
// digit_timer: free-running digit/minor-cycle counters, one-hot digit pulses and
// the major-boundary strobe.
module digit_timer
   import edsac_ctl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   output logic [DIGIT_W-1:0] digit,
   output logic [MINOR_W-1:0] minor,
   output logic [DIGITS-1:0]  d,
   output logic               mb
);

   logic digit_wrap;
   logic minor_last;

   assign digit_wrap = (digit == DIGIT_W'(DIGITS - 1));
   assign minor_last = (minor == MINOR_W'(MINORS - 1));
   assign mb         = digit_wrap && minor_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit <= '0;
         minor <= '0;
      end else begin
         digit <= digit_wrap ? '0 : digit + 1'b1;
         if (digit_wrap) begin
            minor <= minor_last ? '0 : minor + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_decode
      assign d[k] = (digit == DIGIT_W'(k));
   end

endmodule
`default_nettype wire

// File: rtl/main_control_sequencer.sv
`default_nettype none
// main_control_sequencer: steps the machine through Stage 1 (order transfer) and
// Stage 2 (execution) on major-cycle boundaries, with panel start/stop handling.
module main_control_sequencer
   import edsac_ctl_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   main_control_sequencer_if.slave bus
);

   logic [DIGIT_W-1:0] digit;
   logic [MINOR_W-1:0] minor;
   logic               mb;

   state_t             state;
   state_t             next_state;
   logic               pend_start;
   logic               stop_latched;
   logic               flash_fault;
   logic               flash_chk;
   logic [EXEC_W-1:0]  mcnt;

   logic               check_point;
   logic               fault_now;
   logic               eps1;
   logic               epsep;
   logic               enter_idle;

   digit_timer u_timer (
      .clk   (clk),
      .rst   (rst),
      .digit (digit),
      .minor (minor),
      .d     (bus.d),
      .mb    (mb)
   );

   // flash_chk is only ever set while in S2, so it also qualifies the state.
   assign check_point = flash_chk && (digit == DIGIT_W'(DIGITS - 1)) && (minor == '0);
   assign enter_idle  = (state != IDLE) && (next_state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      eps1       = 1'b0;
      epsep      = 1'b0;
      fault_now  = 1'b0;
      case (state)
         IDLE: begin
            if (mb && pend_start) begin
               next_state = S1;
            end
         end
         S1: begin
            if (mb) begin
               eps1       = 1'b1;
               next_state = S2;
            end
         end
         S2: begin
            if (check_point && !bus.order_flash_rdy) begin
               fault_now  = 1'b1;
               next_state = IDLE;
            end else if (mb && (mcnt == EXEC_W'(1))) begin
               epsep      = 1'b1;
               next_state = (bus.stop_order || stop_latched || bus.single_shot) ? IDLE : S1;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_start   <= 1'b0;
         stop_latched <= 1'b0;
         flash_fault  <= 1'b0;
         flash_chk    <= 1'b0;
         mcnt         <= '0;
      end else begin
         // Start is only armed from IDLE; stop takes priority when both arrive together.
         if (state != IDLE || next_state == S1) begin
            pend_start <= 1'b0;
         end else if (bus.stop_req) begin
            pend_start <= 1'b0;
         end else if (bus.start && !flash_fault) begin
            pend_start <= 1'b1;
         end

         if (enter_idle) begin
            stop_latched <= 1'b0;
         end else if (bus.stop_req) begin
            stop_latched <= 1'b1;
         end

         if (fault_now) begin
            flash_fault <= 1'b1;
         end

         if (state == S1 && next_state == S2) begin
            flash_chk <= 1'b1;
            mcnt      <= clamp_len(bus.exec_len);
         end else begin
            if (check_point) begin
               flash_chk <= 1'b0;
            end
            if (state == S2 && mb && mcnt != EXEC_W'(1)) begin
               mcnt <= mcnt - 1'b1;
            end
         end
      end
   end

   assign bus.minor       = minor;
   assign bus.g12         = (state == S1);
   assign bus.g13         = (state == S2);
   assign bus.eps1        = eps1;
   assign bus.epsep       = epsep;
   assign bus.running     = (state != IDLE);
   assign bus.flash_fault = flash_fault;

endmodule
`default_nettype wire

// File: tb/tb_main_control_sequencer.sv
`default_nettype none
// tb_main_control_sequencer: directed and random stimulus checked every cycle
// against a stage-length model of the main control sequencer.
module tb_main_control_sequencer;

   localparam int MAJOR = 576;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   main_control_sequencer_if bus ();

   main_control_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model: absolute cycle count, stage kind, cycles left in the stage and elapsed.
   int m_t     = 0;
   int m_mode  = 0;
   int m_left  = 0;
   int m_pos   = 0;
   bit m_pend  = 0;
   bit m_stop  = 0;
   bit m_fault = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t = 0; m_mode = 0; m_left = 0; m_pos = 0;
         m_pend = 0; m_stop = 0; m_fault = 0;
      end else begin
         bit mb;
         int len;
         mb = (m_t % MAJOR) == MAJOR - 1;
         case (m_mode)
            0: begin
               if (mb && m_pend) begin
                  m_mode = 1; m_left = MAJOR; m_pos = 0; m_pend = 0;
               end else if (bus.stop_req) begin
                  m_pend = 0;
               end else if (bus.start && !m_fault) begin
                  m_pend = 1;
               end
               m_stop = m_stop | bus.stop_req;
            end
            1: begin
               m_left--; m_pos++;
               if (m_left == 0) begin
                  len = (bus.exec_len == 0) ? 1 : int'(bus.exec_len);
                  m_mode = 2; m_left = MAJOR * len; m_pos = 0;
               end
               m_stop = m_stop | bus.stop_req;
            end
            default: begin
               if (m_pos == 35 && !bus.order_flash_rdy) begin
                  m_fault = 1; m_mode = 0; m_stop = 0;
               end else begin
                  m_left--; m_pos++;
                  if (m_left == 0 && (bus.stop_order || m_stop || bus.single_shot)) begin
                     m_mode = 0; m_stop = 0;
                  end else begin
                     if (m_left == 0) begin
                        m_mode = 1; m_left = MAJOR; m_pos = 0;
                     end
                     m_stop = m_stop | bus.stop_req;
                  end
               end
            end
         endcase
         m_t++;
      end
   end

   always @(negedge clk) begin
      logic [35:0] one;
      logic [45:0] e;
      logic [45:0] a;
      one = 36'd1;
      e = {one << (m_t % 36), 4'((m_t / 36) % 16),
           m_mode == 1, m_mode == 2, (m_mode == 1) && (m_left == 1),
           (m_mode == 2) && (m_left == 1), m_mode != 0, m_fault};
      a = {bus.d, bus.minor, bus.g12, bus.g13, bus.eps1, bus.epsep, bus.running, bus.flash_fault};
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL cycle_model t=%0d dut=%h model=%h", m_t, a, e);
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Waits for the selected gate, then counts its high cycles and end pulses.
   task automatic measure(input bit sel, output int len, output int npulse, output bit last);
      int guard;
      bit p;
      guard = 0; len = 0; npulse = 0; last = 0;
      while ((sel ? bus.g13 : bus.g12) == 1'b0 && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      while ((sel ? bus.g13 : bus.g12) == 1'b1 && len < 20000) begin
         p = sel ? bus.epsep : bus.eps1;
         npulse += int'(p);
         last = p;
         len++;
         @(negedge clk);
      end
   endtask

   initial begin
      int  len, np, cnt;
      bit  last;
      bus.start = 0; bus.stop_req = 0; bus.single_shot = 0; bus.stop_order = 0;
      bus.exec_len = 4'd1; bus.order_flash_rdy = 1;

      repeat (3) @(negedge clk);
      chk("reset_state", {bus.d, bus.minor, bus.g12, bus.g13, bus.eps1, bus.epsep,
                          bus.running, bus.flash_fault}, 1024);
      #2 rst = 1'b0;

      repeat (1000) @(negedge clk);
      chk("idle_running", bus.running, 0);
      chk("idle_onehot", $countones(bus.d), 1);
      chk("idle_minor", bus.minor, 11);
      chk("idle_digit", bus.d, 36'd1 << 28);

      pulse_start();
      measure(0, len, np, last);
      chk("s1_len", len, 576);
      chk("s1_eps1", np * 2 + int'(last), 3);
      measure(1, len, np, last);
      chk("s2_len", len, 576);
      chk("s2_epsep", np * 2 + int'(last), 3);
      chk("loop_to_s1", bus.g12, 1);

      bus.exec_len = 4'd3;
      measure(0, len, np, last);
      measure(1, len, np, last);
      chk("s2_len3", len, 1728);
      chk("s2_len3_epsep", np * 2 + int'(last), 3);
      bus.exec_len = 4'd0;
      measure(0, len, np, last);
      measure(1, len, np, last);
      chk("s2_len0", len, 576);

      bus.exec_len = 4'd1;
      repeat (100) @(negedge clk);
      bus.stop_req = 1'b1;
      @(negedge clk);
      bus.stop_req = 1'b0;
      measure(0, len, np, last);
      measure(1, len, np, last);
      chk("stop_s2_len", len, 576);
      chk("stop_epsep", np, 1);
      chk("stop_idle", bus.running, 0);

      bus.order_flash_rdy = 1'b0;
      pulse_start();
      measure(0, len, np, last);
      chk("fault_s1_len", len, 576);
      measure(1, len, np, last);
      chk("fault_s2_len", len, 36);
      chk("fault_no_epsep", np, 0);
      chk("fault_flag", bus.flash_fault, 1);
      bus.order_flash_rdy = 1'b1;
      pulse_start();
      repeat (1200) @(negedge clk);
      chk("fault_blocks_start", bus.running, 0);

      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      pulse_start();
      measure(0, len, np, last);
      cnt = 0;
      while (!(bus.g13 && bus.minor == 4'd7) && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      chk("reach_s2_minor7", int'(bus.g13 && bus.minor == 4'd7), 1);
      #3 rst = 1'b1;
      #1;
      chk("async_reset", {bus.d, bus.minor, bus.g12, bus.g13, bus.eps1, bus.epsep,
                          bus.running, bus.flash_fault}, 1024);
      @(negedge clk);
      #2 rst = 1'b0;
      bus.start = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         cnt++;
      end while (!bus.running && cnt < 2000);
      chk("restart_waits_mb", cnt, 576);

      for (int i = 0; i < 30000; i++) begin
         @(negedge clk);
         bus.start           = ($urandom % 40) == 0;
         bus.stop_req        = ($urandom % 500) == 0;
         bus.stop_order      = ($urandom % 300) == 0;
         bus.exec_len        = 4'($urandom % 4);
         bus.order_flash_rdy = ($urandom % 200) != 0;
         if (($urandom % 400) == 0) bus.single_shot = ~bus.single_shot;
         if (($urandom % 6000) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            #2 rst = 1'b0;
         end
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
